// File: rtl/kl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kl_pipe_pkg
//  Description : Shared sizing defaults and forwarding-select encoding for the
//                pipeline hazard scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
package kl_pipe_pkg;

    localparam int DEPTH_DEFAULT = 6;
    localparam int REG_W_DEFAULT = 3;
    localparam int LAT_W_DEFAULT = 3;
    localparam int FWD_W         = 3;

    // Forwarding mux select codes, m1 is the youngest and highest priority.
    localparam logic [FWD_W-1:0] FWD_REGFILE = 3'd0;
    localparam logic [FWD_W-1:0] FWD_M1      = 3'd1;
    localparam logic [FWD_W-1:0] FWD_M2      = 3'd2;
    localparam logic [FWD_W-1:0] FWD_M3      = 3'd3;
    localparam logic [FWD_W-1:0] FWD_M4      = 3'd4;
    localparam logic [FWD_W-1:0] FWD_M5      = 3'd5;
    localparam logic [FWD_W-1:0] FWD_M6      = 3'd6;

    // Slot index (0-based) to select code.
    function automatic logic [FWD_W-1:0] fwd_slot_code(input int slot);
        return FWD_W'(slot + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_lookup
//  Description : Priority match of one source register against all in-flight
//                slots; reports forwarding select and whether the hit is busy.
//  Revision    : 1.0  initial release
// ============================================================================
module scoreboard_lookup
    import kl_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int REG_W = REG_W_DEFAULT,
    parameter int LAT_W = LAT_W_DEFAULT
) (
    input  logic [DEPTH-1:0]       slot_valid,
    input  logic [DEPTH*REG_W-1:0] slot_dst,
    input  logic [DEPTH*LAT_W-1:0] slot_cnt,
    input  logic [REG_W-1:0]       src,
    input  logic                   src_used,
    output logic [FWD_W-1:0]       sel,
    output logic                   busy
);

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel  = FWD_REGFILE;
        busy = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_used && slot_valid[k] && (slot_dst[k*REG_W +: REG_W] == src)) begin
                sel  = fwd_slot_code(k);
                busy = |slot_cnt[k*LAT_W +: LAT_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : In-flight result tracker producing stall and forwarding
//                selects for two source operands of the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import kl_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int REG_W = REG_W_DEFAULT,
    parameter int LAT_W = LAT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_wr,
    input  logic [REG_W-1:0]       issue_dst,
    input  logic [LAT_W-1:0]       issue_lat,
    input  logic [REG_W-1:0]       src_a,
    input  logic [REG_W-1:0]       src_b,
    input  logic                   src_a_used,
    input  logic                   src_b_used,
    input  logic                   flush,
    output logic                   issue_accept,
    output logic                   stall,
    output logic [FWD_W-1:0]       fwd_sel_a,
    output logic [FWD_W-1:0]       fwd_sel_b,
    output logic [DEPTH-1:0]       m_write,
    output logic [DEPTH*REG_W-1:0] m_num,
    output logic [7:0]             stall_count
);

    localparam logic [LAT_W-1:0] c_max_cnt = LAT_W'(DEPTH - 1);

    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH*REG_W-1:0] r_dst;
    logic [DEPTH*LAT_W-1:0] r_cnt;
    logic [7:0]             r_stall_count;

    logic [DEPTH-1:0]       w_valid_nxt;
    logic [DEPTH*REG_W-1:0] w_dst_nxt;
    logic [DEPTH*LAT_W-1:0] w_cnt_nxt;
    logic [LAT_W-1:0]       w_lat_clip;
    logic                   w_busy_a;
    logic                   w_busy_b;
    logic                   w_stall;
    logic                   w_accept;

    scoreboard_lookup #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .LAT_W (LAT_W)
    ) u_lookup_a (
        .slot_valid (r_valid),
        .slot_dst   (r_dst),
        .slot_cnt   (r_cnt),
        .src        (src_a),
        .src_used   (src_a_used),
        .sel        (fwd_sel_a),
        .busy       (w_busy_a)
    );

    scoreboard_lookup #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .LAT_W (LAT_W)
    ) u_lookup_b (
        .slot_valid (r_valid),
        .slot_dst   (r_dst),
        .slot_cnt   (r_cnt),
        .src        (src_b),
        .src_used   (src_b_used),
        .sel        (fwd_sel_b),
        .busy       (w_busy_b)
    );

    assign w_stall    = issue_valid & (w_busy_a | w_busy_b);
    assign w_accept   = issue_valid & ~w_stall & ~flush;
    assign w_lat_clip = (issue_lat > c_max_cnt) ? c_max_cnt : issue_lat;

    // m1 takes the newly accepted instruction, or a bubble.
    assign w_valid_nxt[0]           = w_accept & issue_wr;
    assign w_dst_nxt[REG_W-1:0]     = w_accept ? issue_dst  : '0;
    assign w_cnt_nxt[LAT_W-1:0]     = w_accept ? w_lat_clip : '0;

    generate
        for (genvar k = 1; k < DEPTH; k++) begin : g_shift
            logic [LAT_W-1:0] w_prev_cnt;

            assign w_prev_cnt = r_cnt[(k-1)*LAT_W +: LAT_W];
            assign w_cnt_nxt[k*LAT_W +: LAT_W] =
                (w_prev_cnt == '0) ? '0 : w_prev_cnt - LAT_W'(1);
            assign w_dst_nxt[k*REG_W +: REG_W] = r_dst[(k-1)*REG_W +: REG_W];

            // A branch redirect kills the instruction currently sitting in m1.
            if (k == 1) begin : g_kill
                assign w_valid_nxt[k] = r_valid[k-1] & ~flush;
            end else begin : g_pass
                assign w_valid_nxt[k] = r_valid[k-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= '0;
            r_dst         <= '0;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_dst   <= w_dst_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall && (r_stall_count != 8'hFF)) begin
                r_stall_count <= r_stall_count + 8'd1;
            end
        end
    end

    assign stall        = w_stall;
    assign issue_accept = w_accept;
    assign m_write      = r_valid;
    assign m_num        = r_dst;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench with a reference slot model and queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_wr, src_a_used, src_b_used, flush;
    logic [2:0]  issue_dst, issue_lat, src_a, src_b;
    logic        issue_accept, stall;
    logic [2:0]  fwd_sel_a, fwd_sel_b;
    logic [5:0]  m_write;
    logic [17:0] m_num;
    logic [7:0]  stall_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int sel_a;
        int sel_b;
        int stl;
        int acc;
        int mw;
        int scnt;
    } exp_t;

    exp_t sb_q[$];

    int mv[6];
    int md[6];
    int mc[6];
    int m_scnt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .src_a        (src_a),
        .src_b        (src_b),
        .src_a_used   (src_a_used),
        .src_b_used   (src_b_used),
        .flush        (flush),
        .issue_accept (issue_accept),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .m_write      (m_write),
        .m_num        (m_num),
        .stall_count  (stall_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 6; k++) begin
            mv[k] = 0;
            md[k] = 0;
            mc[k] = 0;
        end
        m_scnt = 0;
    endfunction

    // First (youngest) matching slot wins.
    function automatic void lookup(input int src, input int used, output int sel, output int busy);
        sel  = 0;
        busy = 0;
        if (used != 0) begin
            for (int k = 0; k < 6; k++) begin
                if (sel == 0 && mv[k] != 0 && md[k] == src) begin
                    sel  = k + 1;
                    busy = (mc[k] != 0) ? 1 : 0;
                end
            end
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   ba, bb;
        lookup(int'(src_a), int'(src_a_used), e.sel_a, ba);
        lookup(int'(src_b), int'(src_b_used), e.sel_b, bb);
        e.stl  = (issue_valid && (ba != 0 || bb != 0)) ? 1 : 0;
        e.acc  = (issue_valid && e.stl == 0 && !flush) ? 1 : 0;
        e.mw   = 0;
        for (int k = 0; k < 6; k++) if (mv[k] != 0) e.mw |= (1 << k);
        e.scnt = m_scnt;
        return e;
    endfunction

    task automatic apply(input int v, input int wr, input int dst, input int lat,
                         input int sa, input int ua, input int sb, input int ub,
                         input int fl);
        exp_t e;
        issue_valid = v[0];
        issue_wr    = wr[0];
        issue_dst   = dst[2:0];
        issue_lat   = lat[2:0];
        src_a       = sa[2:0];
        src_a_used  = ua[0];
        src_b       = sb[2:0];
        src_b_used  = ub[0];
        flush       = fl[0];
        sb_q.push_back(model_outputs());
        #2;
        e = sb_q.pop_front();
        chk("fwd_sel_a", int'(fwd_sel_a), e.sel_a);
        chk("fwd_sel_b", int'(fwd_sel_b), e.sel_b);
        chk("stall", int'(stall), e.stl);
        chk("issue_accept", int'(issue_accept), e.acc);
        chk("m_write", int'(m_write), e.mw);
        chk("stall_count", int'(stall_count), e.scnt);
    endtask

    task automatic tick();
        exp_t e;
        e = model_outputs();
        @(posedge clk);
        for (int k = 5; k >= 1; k--) begin
            mv[k] = mv[k-1];
            md[k] = md[k-1];
            mc[k] = (mc[k-1] > 0) ? mc[k-1] - 1 : 0;
        end
        if (flush) mv[1] = 0;
        mv[0] = (e.acc != 0 && issue_wr) ? 1 : 0;
        md[0] = (e.acc != 0) ? int'(issue_dst) : 0;
        mc[0] = (e.acc != 0) ? ((int'(issue_lat) > 5) ? 5 : int'(issue_lat)) : 0;
        if (e.stl != 0 && m_scnt < 255) m_scnt++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = 3'd3;
        issue_lat   = 3'd0;
        src_a       = 3'd0;
        src_b       = 3'd0;
        src_a_used  = 1'b1;
        src_b_used  = 1'b1;
        flush       = 1'b0;
        #18;
        chk("rst_stall", int'(stall), 0);
        chk("rst_sel_a", int'(fwd_sel_a), 0);
        chk("rst_sel_b", int'(fwd_sel_b), 0);
        chk("rst_m_write", int'(m_write), 0);
        chk("rst_m_num", int'(m_num), 0);
        chk("rst_accept", int'(issue_accept), 1);
        chk("rst_stall_count", int'(stall_count), 0);
        #4;
        rst_n = 1'b1;

        // Single-cycle producer forwards from m1.
        apply(1, 1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("r3_sel_a", int'(fwd_sel_a), 1);
        chk("r3_stall", int'(stall), 0);
        chk("r3_accept", int'(issue_accept), 1);
        chk("r3_m1_num", int'(m_num[2:0]), 3);
        tick();

        // Latency-2 producer: two stall cycles then forward from m3.
        apply(1, 1, 5, 2, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 0, 0, 0, 5, 1, 0);
            chk("r5_stall", int'(stall), 1);
            chk("r5_accept", int'(issue_accept), 0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 5, 1, 0);
        chk("r5_release", int'(stall), 0);
        chk("r5_sel_b", int'(fwd_sel_b), 3);
        chk("r5_accept2", int'(issue_accept), 1);
        chk("r5_stall_count", int'(stall_count), 2);
        tick();

        // r2 in m4 and m1: youngest wins.
        apply(1, 1, 2, 0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 2, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 0, 0, 2, 1, 2, 1, 0);
        chk("r2_young_a", int'(fwd_sel_a), 1);
        chk("r2_young_b", int'(fwd_sel_b), 1);
        chk("r2_m_write", int'(m_write), 6'b001001);
        tick();

        // Flush kills the presented instruction and the m1 entry.
        apply(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 4, 0, 1, 1, 0, 0, 1);
        chk("flush_accept", int'(issue_accept), 0);
        tick();
        apply(1, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("flush_m1m2", int'(m_write[1:0]), 0);
        chk("flush_sel_a", int'(fwd_sel_a), 0);
        tick();

        // Latency 7 clips to 5: five stalls then forward from m6.
        apply(1, 1, 6, 7, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 6, 1, 6, 1, 0);
            chk("lat7_stall", int'(stall), 1);
            tick();
        end
        apply(1, 0, 0, 0, 6, 1, 6, 1, 0);
        chk("lat7_release", int'(stall), 0);
        chk("lat7_sel_a", int'(fwd_sel_a), 6);
        chk("lat7_sel_b", int'(fwd_sel_b), 6);
        tick();

        // Self-referencing source with empty slots must not stall.
        apply(1, 1, 0, 3, 0, 1, 0, 1, 0);
        chk("self_stall", int'(stall), 0);
        tick();

        // Random traffic; flush only without a presented instruction.
        for (int i = 0; i < 60; i++) begin
            int v;
            v = int'($urandom_range(0, 3) != 0);
            apply(v, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), (v == 0) ? int'($urandom_range(0, 1)) : 0);
            tick();
        end

        // Accumulate well over 255 stall cycles.
        for (int r = 0; r < 54; r++) begin
            apply(1, 1, 7, 7, 0, 0, 0, 0, 0);
            tick();
            for (int i = 0; i < 6; i++) begin
                apply(1, 0, 0, 0, 7, 1, 0, 0, 0);
                tick();
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_stall_count", int'(stall_count), 255);
        tick();

        // Asynchronous reset in the middle of a stall.
        apply(1, 1, 4, 5, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 0, 0, 4, 1, 0, 0, 0);
        chk("pre_rst_stall", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", int'(stall), 0);
        chk("async_rst_m_write", int'(m_write), 0);
        chk("async_rst_count", int'(stall_count), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
        apply(1, 0, 0, 0, 4, 1, 4, 1, 0);
        chk("post_rst_sel_a", int'(fwd_sel_a), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
